iob_tb_periph_mux: RTL

//  Testbench-side IOb-native router: one testbench master reaches N_CH peripheral control ports
//  (UART, Ethernet, ...) of the simulation wrapper via channel-select address bits. Adds a
//  per-transaction timeout watchdog that aborts hung accesses and latches a sticky error, so a dead

---
 rtl/iob_tb_periph_mux.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/iob_tb_periph_mux.sv
// Routes one IOb-native master to N_CH peripheral IOb ports using the top address bits as channel select.
// Latency: write valid->ready 2 cycles min, read valid->rvalid 3 cycles min; one access in flight.
// Backpressure: master holds iob_valid_i until iob_ready_o; hung channels are aborted by a watchdog.
//
// Ports:
//   clk_i, cke_i, arst_n_i           clock, clock enable (0 freezes everything), async active-low reset
//   iob_valid_i/addr_i/wdata_i/wstrb_i  master request ({sel, addr}; wstrb==0 means read)
//   iob_rdata_o/ready_o/rvalid_o     master response
//   err_o, err_ch_o                  sticky error flag and the channel select of the first error
//   ch_valid_o/addr_o/wdata_o/wstrb_o   per-channel request, channel k on slice k
//   ch_rdata_i/ready_i/rvalid_i      per-channel response, only the selected slice is looked at
module iob_tb_periph_mux #(
    parameter  int N_CH      = 2,
    parameter  int ADDR_W    = 12,
    parameter  int DATA_W    = 32,
    parameter  int TIMEOUT_W = 8,
    localparam int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic                       clk_i,
    input  logic                       cke_i,
    input  logic                       arst_n_i,
    input  logic                       iob_valid_i,
    input  logic [SEL_W+ADDR_W-1:0]    iob_addr_i,
    input  logic [DATA_W-1:0]          iob_wdata_i,
    input  logic [STRB_W-1:0]          iob_wstrb_i,
    output logic [DATA_W-1:0]          iob_rdata_o,
    output logic                       iob_ready_o,
    output logic                       iob_rvalid_o,
    output logic                       err_o,
    output logic [SEL_W-1:0]           err_ch_o,
    output logic [N_CH-1:0]            ch_valid_o,
    output logic [N_CH*ADDR_W-1:0]     ch_addr_o,
    output logic [N_CH*DATA_W-1:0]     ch_wdata_o,
    output logic [N_CH*STRB_W-1:0]     ch_wstrb_o,
    input  logic [N_CH*DATA_W-1:0]     ch_rdata_i,
    input  logic [N_CH-1:0]            ch_ready_i,
    input  logic [N_CH-1:0]            ch_rvalid_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK,
        ST_RESP,
        ST_RDATA
    } state_t;

    // Abort fires on the cycle the counter holds 2**TIMEOUT_W-2, so the wait lasts 2**TIMEOUT_W-1 cycles.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [SEL_W:0]       N_CH_V   = (SEL_W+1)'(N_CH);

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  is_rd_q, is_rd_d;
    logic                  bad_q, bad_d;
    logic                  cap_q, cap_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [SEL_W-1:0]      err_ch_q, err_ch_d;

    logic [SEL_W-1:0]      sel_in;
    logic                  sel_ok;
    logic                  sel_rdy;
    logic                  sel_rvld;
    logic [DATA_W-1:0]     sel_rdata;

    assign sel_in = iob_addr_i[ADDR_W +: SEL_W];
    assign sel_ok = ({1'b0, sel_in} < N_CH_V);

    // Response mux: only the latched channel is ever observed.
    always_comb begin
        sel_rdy   = 1'b0;
        sel_rvld  = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_rdy   = ch_ready_i[k];
                sel_rvld  = ch_rvalid_i[k];
                sel_rdata = ch_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        is_rd_d  = is_rd_q;
        bad_d    = bad_q;
        cap_d    = cap_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        err_ch_d = err_ch_q;

        unique case (state_q)
            ST_IDLE: begin
                if (iob_valid_i) begin
                    sel_d   = sel_in;
                    addr_d  = iob_addr_i[ADDR_W-1:0];
                    wdata_d = iob_wdata_i;
                    wstrb_d = iob_wstrb_i;
                    is_rd_d = (iob_wstrb_i == '0);
                    cap_d   = 1'b0;
                    cnt_d   = '0;
                    if (sel_ok) begin
                        bad_d   = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        // No such channel: acknowledge straight away with error data.
                        bad_d   = 1'b1;
                        rdata_d = '1;
                        err_d   = 1'b1;
                        if (!err_q) err_ch_d = sel_in;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_REQ: begin
                if (sel_rdy) begin
                    state_d = ST_ACK;
                    // Read data can arrive together with the acknowledge.
                    if (sel_rvld) begin
                        rdata_d = sel_rdata;
                        cap_d   = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    bad_d   = 1'b1;
                    rdata_d = '1;
                    err_d   = 1'b1;
                    if (!err_q) err_ch_d = sel_q;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            ST_ACK: begin
                if (!is_rd_q) begin
                    state_d = ST_IDLE;
                end else if (cap_q || bad_q) begin
                    state_d = ST_RDATA;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (sel_rvld) begin
                    rdata_d = sel_rdata;
                    state_d = ST_RDATA;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    if (!err_q) err_ch_d = sel_q;
                    state_d = ST_RDATA;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            ST_RDATA: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            is_rd_q  <= 1'b0;
            bad_q    <= 1'b0;
            cap_q    <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            err_ch_q <= '0;
        end else if (cke_i) begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            is_rd_q  <= is_rd_d;
            bad_q    <= bad_d;
            cap_q    <= cap_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            err_ch_q <= err_ch_d;
        end
    end

    // All outputs are decoded from registers only, so they change just after the clock edge.
    assign iob_ready_o  = (state_q == ST_ACK);
    assign iob_rvalid_o = (state_q == ST_RDATA);
    assign iob_rdata_o  = (state_q == ST_RDATA) ? rdata_q : '0;
    assign err_o        = err_q;
    assign err_ch_o     = err_ch_q;

    always_comb begin
        ch_valid_o = '0;
        ch_addr_o  = '0;
        ch_wdata_o = '0;
        ch_wstrb_o = '0;
        for (int k = 0; k < N_CH; k++) begin
            if ((state_q == ST_REQ) && (sel_q == SEL_W'(k))) begin
                ch_valid_o[k]                    = 1'b1;
                ch_addr_o[k*ADDR_W +: ADDR_W]    = addr_q;
                ch_wdata_o[k*DATA_W +: DATA_W]   = wdata_q;
                ch_wstrb_o[k*STRB_W +: STRB_W]   = wstrb_q;
            end
        end
    end

endmodule
